// File: rtl/arb_pkg.sv
// Shared constants and helpers for the starvation-guarded arbiter:
// LFSR polynomial step and the wrap-around first-set picker.
package arb_pkg;

    localparam int         LFSR_W     = 8;
    localparam logic [7:0] LFSR_RESET = 8'h01;
    localparam logic [7:0] LFSR_TAP   = 8'hB8;
    localparam int         MAX_REQS   = 16;

    // x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], ^(l & LFSR_TAP)};
    endfunction

    // One-hot of the first set bit of vec at or above start, wrapping within n (a power of two)
    function automatic logic [MAX_REQS-1:0] rr_pick(input logic [MAX_REQS-1:0] vec,
                                                    input logic [3:0]          start,
                                                    input int                  n);
        logic [MAX_REQS-1:0] pick;
        logic                found;
        logic [3:0]          mask;
        logic [3:0]          idx;
        pick  = '0;
        found = 1'b0;
        mask  = 4'(n - 1);
        for (int k = 0; k < MAX_REQS; k++) begin
            idx = (start + 4'(k)) & mask;
            if (k < n && !found && vec[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/starvation_guard_arbiter_lfsr_gen.sv
// 8-bit Fibonacci LFSR that chooses the random scan start; a zero seed is
// replaced by the reset value so the register can never lock up at zero.
module lfsr_gen
    import arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= LFSR_RESET;
        end else if (seed_load) begin
            value <= (seed == '0) ? LFSR_RESET : seed;
        end else begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/starvation_guard_arbiter.sv
// Random-start arbiter with per-requester wait counters; any requester that
// has waited K cycles is force-granted in round-robin order among the urgent.
module starvation_guard_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int K        = 100
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          lfsr_seed,
    input  logic                seed_load,
    input  logic [NUM_REQS-1:0] req,
    output logic [NUM_REQS-1:0] grant,
    output logic                grant_valid,
    output logic                forced,
    output logic [NUM_REQS-1:0] starving
);

    localparam int CNT_W = $clog2(K + 1);
    localparam int IDX_W = $clog2(NUM_REQS);

    logic [LFSR_W-1:0]   lfsr;
    logic [CNT_W-1:0]    wait_cnt [NUM_REQS];
    logic [IDX_W-1:0]    rr_ptr;
    logic [NUM_REQS-1:0] urgent;
    logic [NUM_REQS-1:0] grant_p0;
    logic                forced_p0;
    logic [IDX_W-1:0]    winner_p0;
    logic [3:0]          rand_start;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_W'(K)) ? c : c + 1'b1;
    endfunction

    function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_REQS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    lfsr_gen u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_load (seed_load),
        .seed      (lfsr_seed),
        .value     (lfsr)
    );

    assign rand_start = 4'(lfsr & 8'(NUM_REQS - 1));

    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            urgent[i] = req[i] && (wait_cnt[i] == CNT_W'(K));
        end
    end

    // p0: combinational decision, urgent override first, then LFSR-started scan
    always_comb begin
        grant_p0  = '0;
        forced_p0 = 1'b0;
        if (|urgent) begin
            grant_p0  = NUM_REQS'(rr_pick(MAX_REQS'(urgent), 4'(rr_ptr), NUM_REQS));
            forced_p0 = 1'b1;
        end else if (|req) begin
            grant_p0  = NUM_REQS'(rr_pick(MAX_REQS'(req), rand_start, NUM_REQS));
        end
    end

    assign winner_p0 = onehot_idx(grant_p0);

    // p1: registered grant, counters and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant    <= '0;
            forced   <= 1'b0;
            starving <= '0;
            rr_ptr   <= '0;
            for (int i = 0; i < NUM_REQS; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            grant  <= grant_p0;
            forced <= forced_p0;
            if (forced_p0) begin
                rr_ptr <= winner_p0 + 1'b1;
            end
            for (int i = 0; i < NUM_REQS; i++) begin
                if (req[i] && !grant_p0[i]) begin
                    wait_cnt[i] <= sat_inc(wait_cnt[i]);
                    starving[i] <= (sat_inc(wait_cnt[i]) == CNT_W'(K));
                end else begin
                    wait_cnt[i] <= '0;
                    starving[i] <= 1'b0;
                end
            end
        end
    end

    assign grant_valid = |grant;

endmodule

// File: tb/tb_starvation_guard_arbiter.sv
// Directed bench for starvation_guard_arbiter (NUM_REQS=4, K=4) with an
// integer-level reference model compared on every falling clock edge.
module tb_starvation_guard_arbiter;

    localparam int N  = 4;
    localparam int KK = 4;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         seed_load = 1'b0;
    logic [7:0]   lfsr_seed = 8'h00;
    logic [N-1:0] req       = '0;
    logic [N-1:0] grant;
    logic         grant_valid;
    logic         forced;
    logic [N-1:0] starving;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    starvation_guard_arbiter #(.NUM_REQS(N), .K(KK)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lfsr_seed   (lfsr_seed),
        .seed_load   (seed_load),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .forced      (forced),
        .starving    (starving)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model in plain integers
    int           m_cnt [N] = '{default: 0};
    int           m_lfsr    = 1;
    int           m_rr      = 0;
    logic [N-1:0] m_grant   = '0;
    logic         m_forced  = 1'b0;
    logic [N-1:0] m_starv   = '0;

    function automatic int lfsr_step(input int l);
        return ((l << 1) & 255) | (((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int  w;
        bit  urg;
        int  start;
        int  idx;
        int  nc;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) m_cnt[i] <= 0;
            m_lfsr   <= 1;
            m_rr     <= 0;
            m_grant  <= '0;
            m_forced <= 1'b0;
            m_starv  <= '0;
        end else begin
            w   = -1;
            urg = 1'b0;
            for (int i = 0; i < N; i++) if (req[i] && m_cnt[i] == KK) urg = 1'b1;
            start = urg ? m_rr : (m_lfsr % N);
            for (int k = 0; k < N; k++) begin
                idx = (start + k) % N;
                if (w < 0 && req[idx] && (!urg || m_cnt[idx] == KK)) w = idx;
            end
            m_grant  <= (w >= 0) ? (N'(1) << w) : '0;
            m_forced <= urg;
            if (urg) m_rr <= (w + 1) % N;
            for (int i = 0; i < N; i++) begin
                if (req[i] && i != w) begin
                    nc = (m_cnt[i] + 1 > KK) ? KK : m_cnt[i] + 1;
                    m_cnt[i]   <= nc;
                    m_starv[i] <= (nc == KK);
                end else begin
                    m_cnt[i]   <= 0;
                    m_starv[i] <= 1'b0;
                end
            end
            m_lfsr <= seed_load ? ((lfsr_seed == 8'h00) ? 1 : int'(lfsr_seed)) : lfsr_step(m_lfsr);
        end
    end

    logic [N-1:0] prev_starving = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            check("grant", 32'(grant), 32'(m_grant));
            check("grant_valid", 32'(grant_valid), 32'(|m_grant));
            check("forced", 32'(forced), 32'(m_forced));
            check("starving", 32'(starving), 32'(m_starv));
            for (int i = 0; i < N; i++) check("wait_cnt", 32'(dut.wait_cnt[i]), 32'(m_cnt[i]));
            check("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
            if (forced) check("forced_prev_starving", 32'(|(grant & prev_starving)), 32'd1);
            prev_starving <= starving;
        end else begin
            prev_starving <= '0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int since [N];
        int maxgap [N];

        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_grant_valid", 32'(grant_valid), 32'd0);
        check("rst_forced", 32'(forced), 32'd0);
        check("rst_starving", 32'(starving), 32'd0);
        check("rst_lfsr", 32'(dut.lfsr), 32'h01);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Zero seed falls back to 8'h01, then 8'h42 loads and advances to 8'h84
        @(posedge clk); #1;
        seed_load = 1'b1; lfsr_seed = 8'h00;
        @(posedge clk); #1;
        check("lfsr_zero_seed", 32'(dut.lfsr), 32'h01);
        lfsr_seed = 8'h42;
        @(posedge clk); #1;
        check("lfsr_seed42", 32'(dut.lfsr), 32'h42);
        seed_load = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < N; i++) begin since[i] = 0; maxgap[i] = 0; end
        @(posedge clk); #1;
        check("lfsr_adv84", 32'(dut.lfsr), 32'h84);
        check("grant_start2", 32'(grant), 32'b0100);
        check("forced_random", 32'(forced), 32'd0);
        @(posedge clk); #1;
        check("grant_start0", 32'(grant), 32'b0001);
        @(posedge clk); #1;
        check("grant_start1", 32'(grant), 32'b0010);

        // All requesting: every index must be served within K+N cycles
        repeat (60) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (grant[i]) since[i] = 0;
                else since[i]++;
                if (since[i] > maxgap[i]) maxgap[i] = since[i];
            end
        end
        for (int i = 0; i < N; i++) check("starve_bound", 32'(maxgap[i] <= KK + N), 32'd1);

        // Dropping req[1] for a cycle clears its count
        req = 4'b1101;
        @(posedge clk); #1;
        check("drop_cnt1", 32'(dut.wait_cnt[1]), 32'd0);
        check("drop_starv1", 32'(starving[1]), 32'd0);
        req = 4'b1111;
        repeat (10) @(posedge clk);
        #1;

        // Single requester is granted every cycle, never waits
        req = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        req = 4'b0100;
        @(posedge clk); #1;
        repeat (5) begin
            check("single_grant", 32'(grant), 32'b0100);
            check("single_forced", 32'(forced), 32'd0);
            check("single_cnt2", 32'(dut.wait_cnt[2]), 32'd0);
            @(posedge clk); #1;
        end

        // Asynchronous reset in the middle of a grant
        req = 4'b0010;
        @(posedge clk); #1;
        check("pre_rst_grant", 32'(grant), 32'b0010);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_grant", 32'(grant), 32'd0);
        check("async_rst_valid", 32'(grant_valid), 32'd0);
        check("async_rst_starving", 32'(starving), 32'd0);
        check("async_rst_forced", 32'(forced), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        check("post_rst_no_grant", 32'(grant), 32'd0);
        @(posedge clk); #1;
        check("post_rst_first_grant", 32'(grant), 32'b0010);
        req = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check("idle_grant", 32'(grant), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/starvation_guard_arbiter.md
Name: starvation_guard_arbiter

Overview:
- Shares one resource between NUM_REQS requesters.
- Normal grants are pseudo-random: an LFSR picks where the priority scan starts.
- Per-requester wait counters enforce a hard starvation bound. Any requester waiting K cycles is force-granted.
- Sits where the random arbiter sits today. It closes the liveness gap that the K-cycle starvation property exposes.

Parameters:
- NUM_REQS, 4, number of requesters; must be a power of two, 2..16.
- K, 100, starvation threshold in cycles; K >= 1.
- CNT_W, $clog2(K+1), wait-counter width (derived localparam).
- IDX_W, $clog2(NUM_REQS), index width (derived localparam).

Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- lfsr_seed  in  8  seed value for the LFSR.
- seed_load  in  1  load lfsr_seed into the LFSR at the next posedge.
- req  in  NUM_REQS  request vector, level-sensitive.
- grant  out  NUM_REQS  registered grant, one-hot or zero.
- grant_valid  out  1  equals |grant.
- forced  out  1  current grant came from the starvation override.
- starving  out  NUM_REQS  per-requester flag: wait_cnt[i] == K.

Behaviour:
- Reset: one clock (clk); reset rst_n is asynchronous, active-low.
  - While rst_n is low: grant=0, grant_valid=0, forced=0, starving=0, all wait_cnt=0, LFSR=8'h01, rr_ptr=0.
  - Asserting reset mid-grant clears grant immediately, without waiting for a clock edge.
- LFSR: 8-bit Fibonacci, shift left.
  - Feedback = l[7]^l[5]^l[4]^l[3] (x^8+x^6+x^5+x^4+1, maximal length).
  - Advances every cycle.
  - seed_load=1: next LFSR = lfsr_seed, or 8'h01 if lfsr_seed==0 (lockup guard).
  - A decision in the same cycle as seed_load uses the old LFSR value.
- Decision: combinational next_grant from req, wait_cnt, LFSR and rr_ptr; registered into grant at posedge. Latency 1 cycle. A grant lasts one cycle; there is no locking.
- Priority of paths:
  1. Urgent path:
     - urgent[i] = req[i] && wait_cnt[i]==K.
     - If any urgent: scan from rr_ptr upward with wrap; the first urgent index wins; forced_next=1.
     - rr_ptr <= winner+1 (mod NUM_REQS).
  2. Random path:
     - If there is no urgent but req != 0: start = lfsr[IDX_W-1:0].
     - Scan upward with wrap; the first set req wins; forced_next=0. rr_ptr is unchanged.
  3. req==0: next_grant=0, forced_next=0.
- Wait counters, per i, at each posedge:
  - req[i] && !next_grant[i]: wait_cnt[i] increments, saturating at K.
  - Otherwise: wait_cnt[i] <= 0.
  - Dropping req clears the count.
- Guarantee: a continuously requesting i is granted no later than K+NUM_REQS cycles after its first unserved cycle. Worst case is all requesters urgent at once.
- starving is registered: it reflects wait_cnt==K.
- Simultaneous req drop and grant: the grant is still issued for the cycle already decided. No retraction.
- grant is never non-one-hot. grant[i] is asserted only if req[i] was high in the deciding cycle.

Decomposition:
- Package arb_pkg:
  - LFSR_W=8, LFSR_RESET=8'h01, LFSR_TAP mask 8'hB8.
  - Function lfsr_next(logic [7:0]).
  - Function rr_pick(vec, start) returning a one-hot first-set-from-start with wrap. Shared by both paths.
- Sub-module lfsr_gen: 8-bit LFSR with seed_load and the zero-seed guard.
- Everything else (counters, rr_ptr, grant register) stays in the top module.

Test Plan:
- Reset/seed: rst_n=0, then release; seed_load=1 with lfsr_seed=8'h00 → internal LFSR=8'h01. Repeat with 8'h42 → LFSR=8'h42 one cycle later, advancing to 8'h84 the next.
- Single requester: req=4'b0100 held → grant=4'b0100 every cycle starting one cycle after req rises; forced=0; wait_cnt[2] stays 0.
- Starvation override (K=4): req=4'b1111 held with seed 8'h01 → every index granted within 8 cycles of its last grant. Any grant with forced=1 must coincide with starving[winner]=1 in the prior cycle.
- Simultaneous urgency (K=2, NUM_REQS=4): force all four counters to K by holding req until starving=4'b1111 → forced grants in rr order 0,1,2,3 from rr_ptr=0, all with forced=1.
- Drop clears count: hold req[1] until wait_cnt[1]=3, drop for 1 cycle, reassert → count restarts at 0 and starving[1] stays 0.
- Reset mid-operation: while grant=4'b0010, pull rst_n low between edges → grant=0, grant_valid=0, starving=0 immediately; after release, the first grant appears no earlier than one cycle after req is sampled.
